// File: rtl/braille_pkg.sv
// Shared types and constants for the braille cell player.
// Optional build macro: BRAILLE_GAP_EN (adds a blank gap after each cell).
package braille_pkg;

    // Default dots per cell: 6 = standard braille, 8 = computer braille.
    localparam int CELL_W_DEF = 6;

    // Widest cell this codebase supports; BLANK_CELL is sized to it.
    localparam int MAX_CELL_W = 8;

    // All dots lowered.
    localparam logic [MAX_CELL_W-1:0] BLANK_CELL = '0;

    // Player states. PLAY_GAP is only reachable when BRAILLE_GAP_EN is defined.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        PLAY_GAP = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/braille_cell_player_tick.sv
// braille_tick_gen: loadable down-counter used as the per-cell hold timer.
// tick is high while enabled and the counter sits at zero; a load takes
// priority over counting.
module braille_tick_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down to zero and stay there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/braille_cell_player.sv
// braille_cell_player: stores a line of braille cells and replays it to the
// display driver, one cell per programmable hold period.
// Optional build macro: BRAILLE_GAP_EN inserts a blank gap (rd_data = 0,
// rd_valid = 1) of the same length between consecutive presented cells.
// Handshake: no backpressure; writes are accepted only in IDLE and while not
// full, any other wr_en is dropped and reported on wr_err one cycle later.
module braille_cell_player
    import braille_pkg::*;
#(
    parameter int CELL_W = CELL_W_DEF,
    parameter int DEPTH  = 11,
    parameter int DIV_W  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CELL_W-1:0] wr_data,
    input  logic              line_clr,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              loop_en,
    input  logic [DIV_W-1:0]  div_val,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              wr_err,
    output logic              busy,
    output logic [CELL_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              done,
    output state_t            state
);

    localparam logic [CELL_W-1:0] BLANK = CELL_W'(BLANK_CELL);

    logic [CELL_W-1:0] mem [DEPTH];

    logic             wr_accept;
    logic             wr_drop;
    logic             start_ok;
    logic             playing;
    logic             last;
    logic [IDX_W-1:0] next_idx;
    logic [DIV_W-1:0] hold_val;
    logic             tick;
    logic             tick_load;

    // Write/start qualification, end-of-line detection and hold-time reload value.
    always_comb begin
        wr_accept = wr_en && !line_clr && !full && (state == IDLE);
        wr_drop   = wr_en && !line_clr && (full || state != IDLE);
        start_ok  = play_start && !line_clr && (state == IDLE) && (count != '0);
        playing   = (state == PLAY) || (state == PLAY_GAP);
        last      = (CNT_W'(rd_idx) + CNT_W'(1)) == count;
        next_idx  = last ? '0 : rd_idx + IDX_W'(1);
        hold_val  = (div_val == '0) ? '0 : div_val - DIV_W'(1);
        tick_load = start_ok || (playing && tick);
    end

    assign full = (count == CNT_W'(DEPTH));

    braille_tick_gen #(
        .W(DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (playing),
        .load     (tick_load),
        .load_val (hold_val),
        .tick     (tick)
    );

    // Line buffer storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[count[IDX_W-1:0]] <= wr_data;
        end
    end

    // Player FSM with registered outputs; line_clr overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rd_idx   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            done   <= 1'b0;
            wr_err <= 1'b0;
            if (line_clr) begin
                count    <= '0;
                state    <= IDLE;
                rd_valid <= 1'b0;
                rd_data  <= BLANK;
                busy     <= 1'b0;
            end else begin
                if (wr_accept) begin
                    count <= count + CNT_W'(1);
                end
                if (wr_drop) begin
                    wr_err <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state    <= PLAY;
                            rd_idx   <= '0;
                            rd_data  <= mem[0];
                            rd_valid <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (play_stop) begin
                            state    <= IDLE;
                            rd_valid <= 1'b0;
                            rd_data  <= BLANK;
                            busy     <= 1'b0;
                        end else if (tick) begin
                            if (!last || loop_en) begin
`ifdef BRAILLE_GAP_EN
                                state   <= PLAY_GAP;
                                rd_data <= BLANK;
`else
                                rd_idx  <= next_idx;
                                rd_data <= mem[next_idx];
`endif
                            end else begin
                                state    <= DONE;
                                done     <= 1'b1;
                                rd_valid <= 1'b0;
                                rd_data  <= BLANK;
                                busy     <= 1'b0;
                            end
                        end
                    end
`ifdef BRAILLE_GAP_EN
                    PLAY_GAP: begin
                        if (play_stop) begin
                            state    <= IDLE;
                            rd_valid <= 1'b0;
                            rd_data  <= BLANK;
                            busy     <= 1'b0;
                        end else if (tick) begin
                            state   <= PLAY;
                            rd_idx  <= next_idx;
                            rd_data <= mem[next_idx];
                        end
                    end
`endif
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        rd_valid <= 1'b0;
                        rd_data  <= BLANK;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_braille_cell_player.sv
// Directed testbench for braille_cell_player (DEPTH = 11, CELL_W = 6, DIV_W = 8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_braille_cell_player;
    import braille_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [5:0] wr_data;
    logic       line_clr;
    logic       play_start;
    logic       play_stop;
    logic       loop_en;
    logic [7:0] div_val;
    logic [3:0] count;
    logic       full;
    logic       wr_err;
    logic       busy;
    logic [5:0] rd_data;
    logic       rd_valid;
    logic [3:0] rd_idx;
    logic       done;
    state_t     state;

    int checks;
    int errors;

    braille_cell_player dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .line_clr   (line_clr),
        .play_start (play_start),
        .play_stop  (play_stop),
        .loop_en    (loop_en),
        .div_val    (div_val),
        .count      (count),
        .full       (full),
        .wr_err     (wr_err),
        .busy       (busy),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_idx     (rd_idx),
        .done       (done),
        .state      (state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input logic [5:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic clear_line();
        line_clr = 1'b1;
        step();
        line_clr = 1'b0;
    endtask

    task automatic start_play();
        play_start = 1'b1;
        step();
        play_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        if ({count, full, wr_err, busy, rd_data, rd_valid, rd_idx, done} !== '0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {count, full, wr_err, busy, rd_data, rd_valid, rd_idx, done});
            errors++;
        end
        checks++;
        if (state !== IDLE) begin
            $display("FAIL reset_state: got %0d expected %0d", state, IDLE); errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [5:0] exp_d [3];
        exp_d[0] = 6'h01; exp_d[1] = 6'h03; exp_d[2] = 6'h09;
        clear_line();
        write_cell(6'h01);
        write_cell(6'h03);
        write_cell(6'h09);
        if (count !== 4'd3) begin
            $display("FAIL basic_count: got %0d expected 3", count); errors++;
        end
        checks++;
        div_val = 8'd3;
        loop_en = 1'b0;
        start_play();
        for (int c = 1; c <= 9; c++) begin
            if (rd_data !== exp_d[(c-1)/3] || rd_valid !== 1'b1 || busy !== 1'b1 ||
                rd_idx !== 4'((c-1)/3)) begin
                $display("FAIL basic_cycle%0d: got data %h valid %b busy %b idx %0d expected data %h valid 1 busy 1 idx %0d",
                         c, rd_data, rd_valid, busy, rd_idx, exp_d[(c-1)/3], (c-1)/3);
                errors++;
            end
            checks++;
            if (c == 3) begin
                if (wr_err !== 1'b1 || count !== 4'd3) begin
                    $display("FAIL play_write_drop: got wr_err %b count %0d expected wr_err 1 count 3",
                             wr_err, count);
                    errors++;
                end
                checks++;
            end
            wr_en      = (c == 2);
            wr_data    = 6'h2A;
            play_start = (c == 5);
            step();
        end
        wr_en = 1'b0;
        play_start = 1'b0;
        if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 6'h00) begin
            $display("FAIL basic_done: got done %b valid %b busy %b data %h expected 1 0 0 00",
                     done, rd_valid, busy, rd_data);
            errors++;
        end
        checks++;
        step();
        if (done !== 1'b0 || state !== IDLE) begin
            $display("FAIL basic_idle: got done %b state %0d expected done 0 state %0d",
                     done, state, IDLE);
            errors++;
        end
        checks++;
        // A fourth cell lands at index 3; replay all four with div_val = 1.
        write_cell(6'h15);
        div_val = 8'd1;
        start_play();
        for (int c = 0; c < 4; c++) begin
            if (rd_idx !== 4'(c) || rd_data !== (c == 3 ? 6'h15 : exp_d[c % 3])) begin
                $display("FAIL replay4_cell%0d: got idx %0d data %h expected idx %0d data %h",
                         c, rd_idx, rd_data, c, (c == 3 ? 6'h15 : exp_d[c % 3]));
                errors++;
            end
            checks++;
            step();
        end
        if (done !== 1'b1) begin
            $display("FAIL replay4_done: got %b expected 1", done); errors++;
        end
        checks++;
        step();
    endtask

    task automatic test_overflow();
        clear_line();
        for (int i = 0; i < 11; i++) begin
            write_cell(6'(i + 1));
        end
        if (full !== 1'b1 || count !== 4'd11 || wr_err !== 1'b0) begin
            $display("FAIL full_after_11: got full %b count %0d wr_err %b expected 1 11 0",
                     full, count, wr_err);
            errors++;
        end
        checks++;
        write_cell(6'h0C);
        if (wr_err !== 1'b1 || count !== 4'd11) begin
            $display("FAIL overflow_drop: got wr_err %b count %0d expected 1 11", wr_err, count);
            errors++;
        end
        checks++;
        step();
        if (wr_err !== 1'b0) begin
            $display("FAIL wr_err_pulse: got %b expected 0", wr_err); errors++;
        end
        checks++;
        // Full line replays intact at one cycle per cell.
        div_val = 8'd1;
        loop_en = 1'b0;
        start_play();
        for (int i = 0; i < 11; i++) begin
            if (rd_idx !== 4'(i) || rd_data !== 6'(i + 1) || rd_valid !== 1'b1) begin
                $display("FAIL full_replay_cell%0d: got idx %0d data %h valid %b expected idx %0d data %h valid 1",
                         i, rd_idx, rd_data, rd_valid, i, 6'(i + 1));
                errors++;
            end
            checks++;
            step();
        end
        if (done !== 1'b1) begin
            $display("FAIL full_replay_done: got %b expected 1", done); errors++;
        end
        checks++;
        step();
    endtask

    task automatic test_loop_stop();
        clear_line();
        write_cell(6'h11);
        write_cell(6'h22);
        div_val = 8'd0;
        loop_en = 1'b1;
        start_play();
        for (int c = 0; c < 5; c++) begin
            if (rd_idx !== 4'(c % 2) || rd_data !== (c % 2 == 0 ? 6'h11 : 6'h22) || rd_valid !== 1'b1) begin
                $display("FAIL loop_cycle%0d: got idx %0d data %h valid %b expected idx %0d data %h valid 1",
                         c, rd_idx, rd_data, rd_valid, c % 2, (c % 2 == 0 ? 6'h11 : 6'h22));
                errors++;
            end
            checks++;
            if (c < 4) step();
        end
        play_stop  = 1'b1;
        play_start = 1'b1;
        step();
        play_stop  = 1'b0;
        play_start = 1'b0;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state !== IDLE) begin
            $display("FAIL stop: got valid %b busy %b done %b state %0d expected 0 0 0 %0d",
                     rd_valid, busy, done, state, IDLE);
            errors++;
        end
        checks++;
        step();
        if (done !== 1'b0 || state !== IDLE || rd_valid !== 1'b0) begin
            $display("FAIL stop_settled: got done %b state %0d valid %b expected 0 %0d 0",
                     done, state, rd_valid, IDLE);
            errors++;
        end
        checks++;
        loop_en = 1'b0;
    endtask

    task automatic test_clear();
        clear_line();
        write_cell(6'h05);
        write_cell(6'h06);
        div_val = 8'd2;
        start_play();
        step();
        line_clr = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 6'h3F;
        step();
        line_clr = 1'b0;
        wr_en    = 1'b0;
        if (count !== 4'd0 || state !== IDLE || rd_valid !== 1'b0 || wr_err !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL clear_priority: got count %0d state %0d valid %b wr_err %b busy %b done %b expected 0 %0d 0 0 0 0",
                     count, state, rd_valid, wr_err, busy, done, IDLE);
            errors++;
        end
        checks++;
        start_play();
        if (state !== IDLE || rd_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL empty_start_ignored: got state %0d valid %b busy %b expected %0d 0 0",
                     state, rd_valid, busy, IDLE);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        clear_line();
        for (int i = 0; i < 4; i++) write_cell(6'(8 + i));
        div_val = 8'd1;
        start_play();
        step();
        step();
        if (rd_idx !== 4'd2 || rd_data !== 6'h0A) begin
            $display("FAIL pre_reset_idx: got idx %0d data %h expected 2 0a", rd_idx, rd_data);
            errors++;
        end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        if ({count, full, wr_err, busy, rd_data, rd_valid, rd_idx, done} !== '0 || state !== IDLE) begin
            $display("FAIL async_reset: got %h state %0d expected 0 state %0d",
                     {count, full, wr_err, busy, rd_data, rd_valid, rd_idx, done}, state, IDLE);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        step();
        if (count !== 4'd0 || state !== IDLE) begin
            $display("FAIL post_reset: got count %0d state %0d expected 0 %0d", count, state, IDLE);
            errors++;
        end
        checks++;
    endtask

`ifdef BRAILLE_GAP_EN
    task automatic test_gap();
        logic [5:0] exp_d [6];
        logic [3:0] exp_i [6];
        exp_d[0] = 6'h3F; exp_d[1] = 6'h3F; exp_d[2] = 6'h00;
        exp_d[3] = 6'h00; exp_d[4] = 6'h3F; exp_d[5] = 6'h3F;
        exp_i[0] = 4'd0; exp_i[1] = 4'd0; exp_i[2] = 4'd0;
        exp_i[3] = 4'd0; exp_i[4] = 4'd1; exp_i[5] = 4'd1;
        clear_line();
        write_cell(6'h3F);
        write_cell(6'h3F);
        div_val = 8'd2;
        loop_en = 1'b0;
        start_play();
        for (int c = 0; c < 6; c++) begin
            if (rd_data !== exp_d[c] || rd_idx !== exp_i[c] || rd_valid !== 1'b1) begin
                $display("FAIL gap_cycle%0d: got data %h idx %0d valid %b expected data %h idx %0d valid 1",
                         c + 1, rd_data, rd_idx, rd_valid, exp_d[c], exp_i[c]);
                errors++;
            end
            checks++;
            step();
        end
        if (done !== 1'b1 || rd_valid !== 1'b0) begin
            $display("FAIL gap_done: got done %b valid %b expected 1 0", done, rd_valid);
            errors++;
        end
        checks++;
        step();
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = '0;
        line_clr   = 1'b0;
        play_start = 1'b0;
        play_stop  = 1'b0;
        loop_en    = 1'b0;
        div_val    = '0;
        test_reset();
        test_overflow();
        test_clear();
`ifdef BRAILLE_GAP_EN
        test_gap();
`else
        test_basic();
        test_loop_stop();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/braille_cell_player.md
Name: braille_cell_player

Overview:
- Parametrised successor to the braille cell store-and-replay buffer.
- Accepts braille cells (one bit per dot) from the encoder into a line buffer of DEPTH cells.
- Replays the stored line to the actuator/display driver, one cell per programmable tick period.
- Adds full/error flags, start/stop/loop control and a done pulse.

Parameters:
- CELL_W, 6, dots per cell (6 = standard braille, 8 = computer braille).
- DEPTH, 11, number of cells in the line buffer.
- DIV_W, 8, width of the per-cell hold-time divider.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one cell at the current fill position
- wr_data  in  CELL_W  cell to store
- line_clr  in  1  empty the buffer and abort playback
- play_start  in  1  begin replay from cell 0
- play_stop  in  1  abort replay
- loop_en  in  1  at end of line, restart from cell 0 instead of finishing
- div_val  in  DIV_W  cycles each cell is held; 0 is treated as 1
- count  out  $clog2(DEPTH+1)  cells stored
- full  out  1  count == DEPTH
- wr_err  out  1  one-cycle pulse when a write is dropped
- busy  out  1  state is PLAY
- rd_data  out  CELL_W  cell being presented; all-zero when rd_valid = 0
- rd_valid  out  1  rd_data is meaningful
- rd_idx  out  $clog2(DEPTH)  index of the presented cell
- done  out  1  one-cycle pulse when a non-looping replay completes

Behaviour:
- Reset: all outputs 0, count 0, state IDLE, tick counter 0. Memory contents need not be cleared.
- States: IDLE, PLAY, DONE.
- Write accept: wr_en && !full && state == IDLE stores mem[count] <= wr_data and increments count.
- Write drop: wr_en while full or not IDLE leaves memory untouched and pulses wr_err the next cycle.
- line_clr has highest priority, in any state:
  - count <= 0, state <= IDLE, rd_valid <= 0; no done, no wr_err.
  - A wr_en in the same cycle is discarded silently.
- IDLE -> PLAY:
  - On play_start with count > 0: the next cycle has rd_idx = 0, rd_data = mem[0], rd_valid = 1, busy = 1.
  - The tick counter loads max(div_val,1) - 1.
  - play_start with count == 0 is ignored.
- In PLAY:
  - The tick counter decrements every cycle; each cell is therefore presented for exactly max(div_val,1) cycles.
  - div_val is sampled at each cell load; changing it mid-cell takes effect on the next cell.
- End of a cell period:
  - If rd_idx < count-1: rd_idx increments.
  - Else if loop_en: rd_idx returns to 0.
  - Else: state -> DONE.
- DONE: held for one cycle with done = 1, rd_valid = 0, busy = 0, then IDLE.
- play_stop in PLAY: next cycle IDLE, rd_valid = 0, no done. If play_stop and play_start are both asserted, play_stop wins.
- play_start while in PLAY is ignored; it does not restart playback.
- rst mid-playback returns immediately (asynchronously) to reset values.

Optional Feature:
- Macro: BRAILLE_GAP_EN.
- Defined:
  - After every cell period, a gap period of the same length is presented with rd_data = 0, rd_valid = 1, rd_idx unchanged.
  - This lets readers separate repeated identical cells.
  - No gap follows the final cell in non-loop mode; in loop mode a gap is inserted between the last cell and cell 0.
  - Adds one state bit, PLAY_GAP.
- Undefined: cells are presented back-to-back, exactly as described under Behaviour.

Decomposition:
- Package braille_pkg holds:
  - CELL_W default
  - state enum (IDLE, PLAY, PLAY_GAP, DONE)
  - BLANK_CELL constant (all zeros)
- Sub-module braille_tick_gen:
  - Loadable down-counter.
  - Inputs load and load_val; output tick, asserted when the counter reaches 0 while enabled.
  - Instantiated once for the per-cell hold timer.

Test Plan:
- Basic replay: write 0x01, 0x03, 0x09; div_val = 3; play_start at cycle 0.
  - Expect rd_data 0x01 (cycles 1-3), 0x03 (4-6), 0x09 (7-9).
  - done = 1 at cycle 10, IDLE at cycle 11.
- Overflow and write lockout: write 12 cells with DEPTH = 11.
  - full = 1 after the 11th write; the 12th pulses wr_err; count stays 11.
  - wr_en during PLAY pulses wr_err and leaves mem unchanged.
- Loop and stop: 2 cells, div_val = 0, loop_en = 1.
  - Expect rd_idx sequence 0, 1, 0, 1 on consecutive cycles.
  - play_stop sets rd_valid = 0 the next cycle, with no done pulse.
- Clear priority: assert line_clr together with wr_en during PLAY.
  - Next cycle: count = 0, state IDLE, rd_valid = 0, wr_err = 0.
  - A subsequent play_start is ignored.
- Reset mid-operation: assert rst during PLAY at rd_idx = 2.
  - All outputs 0 asynchronously; after release, count = 0.
- With BRAILLE_GAP_EN: 2 cells (0x3F, 0x3F), div_val = 2.
  - Expect rd_data 0x3F, 0x3F, 0x00, 0x00, 0x3F, 0x3F, then done.
